// File: rtl/dac_sample_sequencer_pkg.sv
// Shared definitions for the DAC sample sequencer: word layout, the default
// minimum sample period and the FIFO level-width helper.
package dac_sample_sequencer_pkg;

    // Word sent to the SPI controller: {chan[3:0], code[11:0]}
    localparam int WORD_W   = 16;
    localparam int CHAN_MSB = 15;
    localparam int CHAN_LSB = 12;
    localparam int CODE_MSB = 11;
    localparam int CODE_LSB = 0;

    // Must exceed the cycle count of one full SPI transaction.
    localparam int DEFAULT_MIN_PERIOD = 64;

    // An occupancy counter has to represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dac_sync_fifo.sv
// Single-clock FIFO holding 16-bit DAC words. The caller only pushes when
// not full and only pops when not empty. Flush empties the FIFO on the next
// edge and overrides any push or pop issued in the same cycle.
module dac_sync_fifo
    import dac_sample_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic                            flush,
    input  logic [WORD_W-1:0]               wr_data,
    output logic [WORD_W-1:0]               rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [level_width(DEPTH)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Qualify requests: flush wins, and the flags guard against misuse.
    always_comb begin
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
    end

    // Status flags derived from the occupancy count.
    always_comb begin
        full  = (level == FULL_LEVEL);
        empty = (level == '0);
    end

    // Head of the FIFO is always visible; it is consumed on pop.
    always_comb begin
        rd_data = mem[rd_ptr];
    end

    // Storage write; no reset needed since data is only read when valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (flush) begin
            level <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Paces samples from a valid/ready stream out to the DAC SPI controller:
// one word per sample period, announced by a single-cycle renew strobe.
//
// Input handshake: a sample transfers on any rising clk edge where
// s_valid && s_ready. s_ready depends only on FIFO fullness (never on
// s_valid), and a full FIFO refuses samples even while it pops, so there
// is no combinational pass-through from pop to s_ready.
module dac_sample_sequencer
    import dac_sample_sequencer_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_i,
    input  logic                            flush_i,
    input  logic [CNT_W-1:0]                rate_i,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [3:0]                      s_chan,
    input  logic [11:0]                     s_code,
    output logic [WORD_W-1:0]               data_o,
    output logic                            renew_o,
    output logic                            dac_en_o,
    output logic                            underrun_o,
    input  logic                            clr_underrun_i,
    output logic [level_width(DEPTH)-1:0]   level_o
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    logic              en_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  eff_period;
    logic [CNT_W-1:0]  eff_last;
    logic              run;
    logic              tick;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              underrun_evt;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    // Effective period is clamped so strobes never outrun an SPI transfer.
    always_comb begin
        eff_period = (rate_i < MIN_P) ? MIN_P : rate_i;
        eff_last   = eff_period - CNT_W'(1);
    end

    // The counter starts one cycle after en_i rises (en_q), which places the
    // first tick exactly eff_period cycles after enable; dropping en_i stops
    // ticks immediately. ">=" catches a period shortened mid-count.
    always_comb begin
        run  = en_i && en_q;
        tick = run && (cnt >= eff_last);
    end

    // Sample-word packing and FIFO request qualification; flush cancels both.
    always_comb begin
        wr_word                    = '0;
        wr_word[CHAN_MSB:CHAN_LSB] = s_chan;
        wr_word[CODE_MSB:CODE_LSB] = s_code;
        fifo_push                  = s_valid && s_ready && !flush_i;
        fifo_pop                   = tick && !fifo_empty && !flush_i;
        underrun_evt               = tick && fifo_empty && !flush_i;
    end

    // Ready reflects fullness only.
    always_comb begin
        s_ready = !fifo_full;
    end

    // Registered enable: feeds the SPI controller and gates the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_i;
        end
    end

    always_comb begin
        dac_en_o = en_q;
    end

    // Period counter: held at zero while idle, wraps to zero on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Output word and strobe: data_o changes only when a word is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o  <= '0;
            renew_o <= 1'b0;
        end else begin
            renew_o <= fifo_pop;
            if (fifo_pop) begin
                data_o <= rd_word;
            end
        end
    end

    // Sticky underrun flag; a new event takes priority over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_o <= 1'b0;
        end else if (underrun_evt) begin
            underrun_o <= 1'b1;
        end else if (clr_underrun_i) begin
            underrun_o <= 1'b0;
        end
    end

    dac_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (flush_i),
        .wr_data (wr_word),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level_o)
    );

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Bench for dac_sample_sequencer: directed scenarios; popped words are
// compared against an expected queue by a monitor on each renew strobe.
module tb_dac_sample_sequencer;

    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             en_i;
    logic             flush_i;
    logic [15:0]      rate_i;
    logic             s_valid;
    logic             s_ready;
    logic [3:0]       s_chan;
    logic [11:0]      s_code;
    logic [15:0]      data_o;
    logic             renew_o;
    logic             dac_en_o;
    logic             underrun_o;
    logic             clr_underrun_i;
    logic [LVL_W-1:0] level_o;

    logic [15:0] exp_q[$];
    int          renew_cyc_q[$];
    int          cyc;
    int          renew_seen;
    int          pass_cnt;
    int          total_cnt;
    int          n;

    dac_sample_sequencer #(
        .DEPTH      (DEPTH),
        .MIN_PERIOD (64),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en_i),
        .flush_i        (flush_i),
        .rate_i         (rate_i),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_chan         (s_chan),
        .s_code         (s_code),
        .data_o         (data_o),
        .renew_o        (renew_o),
        .dac_en_o       (dac_en_o),
        .underrun_o     (underrun_o),
        .clr_underrun_i (clr_underrun_i),
        .level_o        (level_o)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: every renew must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && renew_o) begin
            renew_seen++;
            renew_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("renew_unexpected", 32'(renew_o), 32'd0);
            end else begin
                check("renew_data", 32'(data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks; all run from just after a rising edge.
    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        en_i = 1'b0; flush_i = 1'b0; rate_i = 16'd0; s_valid = 1'b0;
        s_chan = 4'd0; s_code = 12'd0; clr_underrun_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        renew_cyc_q.delete();
        renew_seen = 0;
        rst = 1'b0;
    endtask

    task automatic push_sample(input logic [3:0] chan, input logic [11:0] code);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_chan = chan;
        s_code = code;
        while (!s_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!s_ready) begin
            check("push_timeout", 32'(s_ready), 32'd1);
        end else begin
            exp_q.push_back({chan, code});
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic enable(input logic [15:0] rate);
        rate_i = rate;
        en_i = 1'b1;
        n = cyc;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; renew_seen = 0;
        rst = 1'b1; en_i = 1'b0; flush_i = 1'b0; rate_i = 16'd0; s_valid = 1'b0;
        s_chan = 4'd0; s_code = 12'd0; clr_underrun_i = 1'b0;

        // Reset / idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_renew", 32'(renew_o), 32'h0);
        check("rst_dac_en", 32'(dac_en_o), 32'h0);
        check("rst_underrun", 32'(underrun_o), 32'h0);
        check("rst_level", 32'(level_o), 32'h0);
        do_reset();
        check("idle_ready", 32'(s_ready), 32'h1);
        push_sample(4'h1, 12'h123);
        push_sample(4'h2, 12'h456);
        push_sample(4'h3, 12'h789);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("idle_level", 32'(level_o), 32'd3);
        check("idle_renews", 32'(renew_seen), 32'd0);
        check("idle_dac_en", 32'(dac_en_o), 32'h0);
        check("idle_data", 32'(data_o), 32'h0);

        // Basic pacing at rate 100
        do_reset();
        push_sample(4'h1, 12'h123);
        push_sample(4'h2, 12'h456);
        enable(16'd100);
        wait_cyc(n + 1);
        @(negedge clk);
        check("pace_dac_en", 32'(dac_en_o), 32'h1);
        wait_cyc(n + 205);
        @(negedge clk);
        check("pace_count", 32'(renew_cyc_q.size()), 32'd2);
        if (renew_cyc_q.size() >= 2) begin
            check("pace_first", 32'(renew_cyc_q[0] - n), 32'd101);
            check("pace_second", 32'(renew_cyc_q[1] - n), 32'd201);
        end

        // Clamp: rate 10 is raised to 64
        do_reset();
        push_sample(4'h3, 12'h001);
        push_sample(4'h4, 12'h002);
        push_sample(4'h5, 12'h003);
        enable(16'd10);
        wait_cyc(n + 200);
        @(negedge clk);
        check("clamp_count", 32'(renew_cyc_q.size()), 32'd3);
        if (renew_cyc_q.size() >= 3) begin
            check("clamp_first", 32'(renew_cyc_q[0] - n), 32'd65);
            check("clamp_gap1", 32'(renew_cyc_q[1] - renew_cyc_q[0]), 32'd64);
            check("clamp_gap2", 32'(renew_cyc_q[2] - renew_cyc_q[1]), 32'd64);
        end

        // Underrun with one sample at rate 80
        do_reset();
        push_sample(4'h1, 12'h123);
        enable(16'd80);
        wait_cyc(n + 160);
        @(negedge clk);
        check("ur_before", 32'(underrun_o), 32'h0);
        wait_cyc(n + 161);
        @(negedge clk);
        check("ur_set", 32'(underrun_o), 32'h1);
        check("ur_no_renew", 32'(renew_o), 32'h0);
        check("ur_data_hold", 32'(data_o), 32'h1123);
        wait_cyc(n + 170);
        clr_underrun_i = 1'b1;
        wait_cyc(n + 171);
        clr_underrun_i = 1'b0;
        @(negedge clk);
        check("ur_clear", 32'(underrun_o), 32'h0);
        wait_cyc(n + 240);
        clr_underrun_i = 1'b1;
        wait_cyc(n + 241);
        clr_underrun_i = 1'b0;
        @(negedge clk);
        check("ur_set_wins", 32'(underrun_o), 32'h1);
        check("ur_renews", 32'(renew_seen), 32'd1);

        // Full FIFO: no pass-through in the pop cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_sample(4'(i + 1), 12'(16 * i + 7));
        @(negedge clk);
        check("full_level", 32'(level_o), 32'd8);
        check("full_ready", 32'(s_ready), 32'h0);
        enable(16'd64);
        wait_cyc(n + 64);
        s_valid = 1'b1; s_chan = 4'hF; s_code = 12'hFFF;
        @(negedge clk);
        check("full_pop_ready", 32'(s_ready), 32'h0);
        wait_cyc(n + 65);
        s_valid = 1'b0;
        @(negedge clk);
        check("full_after_level", 32'(level_o), 32'd7);
        check("full_after_ready", 32'(s_ready), 32'h1);

        // Push and pop in the same cycle at level 4
        do_reset();
        for (int i = 0; i < 4; i++) push_sample(4'(i + 8), 12'(12'h100 * i + 12'h0AB));
        enable(16'd64);
        wait_cyc(n + 64);
        s_valid = 1'b1; s_chan = 4'hC; s_code = 12'h3C3;
        exp_q.push_back(16'hC3C3);
        @(negedge clk);
        check("simul_pre_level", 32'(level_o), 32'd4);
        wait_cyc(n + 65);
        s_valid = 1'b0;
        @(negedge clk);
        check("simul_level", 32'(level_o), 32'd4);
        check("simul_renew", 32'(renew_o), 32'h1);

        // Flush on a tick cycle, then reset mid-period
        do_reset();
        push_sample(4'h4, 12'hAAA);
        push_sample(4'h5, 12'hBBB);
        enable(16'd64);
        wait_cyc(n + 128);
        flush_i = 1'b1;
        s_valid = 1'b1; s_chan = 4'h6; s_code = 12'hCCC;
        exp_q.delete();
        wait_cyc(n + 129);
        flush_i = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("flush_renew", 32'(renew_o), 32'h0);
        check("flush_underrun", 32'(underrun_o), 32'h0);
        check("flush_level", 32'(level_o), 32'd0);
        check("flush_data", 32'(data_o), 32'h4AAA);
        wait_cyc(n + 150);
        @(negedge clk);
        check("mid_dac_en", 32'(dac_en_o), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_data", 32'(data_o), 32'h0);
        check("async_dac_en", 32'(dac_en_o), 32'h0);
        check("async_renew", 32'(renew_o), 32'h0);
        check("async_underrun", 32'(underrun_o), 32'h0);
        check("async_level", 32'(level_o), 32'h0);
        en_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
